// File: rtl/random_range_gen.sv
// Pseudo-random value generator: free-running 16-bit LFSR, sampled on request and
// reduced modulo (MAX_VAL-MIN_VAL+1) by a 16-step restoring remainder unit.
// Optional seed-load port pair is enabled by defining RANDOM_SEED_LOAD_EN.
module random_range_gen #(
    parameter int          WIDTH   = 14,
    parameter int          MIN_VAL = 1000,
    parameter int          MAX_VAL = 3000,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic             Clk,
    input  logic             Rst,
`ifdef RANDOM_SEED_LOAD_EN
    input  logic [15:0]      Seed,
    input  logic             SeedLoad,
`endif
    input  logic             Req,
    output logic             Ready,
    output logic             Valid,
    output logic [WIDTH-1:0] RandomValue
);

    localparam int             RANGE   = MAX_VAL - MIN_VAL + 1;
    localparam logic [WIDTH:0] RANGE_W = (WIDTH+1)'(RANGE);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Fibonacci LFSR step, taps 16/14/13/11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        lfsr_step = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [15:0]      lfsr_r;
    logic [15:0]      lfsr_nxt_s;
    logic [15:0]      sample_r;
    logic [15:0]      sample_nxt_s;
    logic [3:0]       count_r;
    logic [3:0]       count_nxt_s;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH:0]   rem_nxt_s;
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   rem_step_s;
    logic             ready_r;
    logic             ready_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;
    logic [WIDTH-1:0] value_r;
    logic [WIDTH-1:0] value_nxt_s;

    // LFSR next value: shift every cycle, optionally replaced by a seed load.
    always_comb begin
        lfsr_nxt_s = lfsr_step(lfsr_r);
`ifdef RANDOM_SEED_LOAD_EN
        if (SeedLoad) begin
            // A zero seed would lock the LFSR, so fall back to the default seed.
            lfsr_nxt_s = (Seed == 16'h0000) ? SEED : Seed;
        end else begin
            lfsr_nxt_s = lfsr_step(lfsr_r);
        end
`endif
    end

    // One restoring remainder step, consuming the sample MSB first.
    always_comb begin
        rem_shift_s = {rem_r[WIDTH-1:0], sample_r[15]};
        if (rem_shift_s >= RANGE_W) begin
            rem_step_s = rem_shift_s - RANGE_W;
        end else begin
            rem_step_s = rem_shift_s;
        end
    end

    // Control FSM next-state and datapath next values.
    always_comb begin
        state_nxt_s  = state_r;
        sample_nxt_s = sample_r;
        count_nxt_s  = count_r;
        rem_nxt_s    = rem_r;
        ready_nxt_s  = ready_r;
        valid_nxt_s  = 1'b0;
        value_nxt_s  = value_r;
        case (state_r)
            ST_IDLE: begin
                if (Req) begin
                    sample_nxt_s = lfsr_r;
                    rem_nxt_s    = {(WIDTH+1){1'b0}};
                    count_nxt_s  = 4'd0;
                    state_nxt_s  = ST_BUSY;
                    ready_nxt_s  = 1'b0;
                end else begin
                    ready_nxt_s  = 1'b1;
                end
            end
            ST_BUSY: begin
                rem_nxt_s    = rem_step_s;
                sample_nxt_s = {sample_r[14:0], 1'b0};
                count_nxt_s  = count_r + 4'd1;
                if (count_r == 4'd15) begin
                    // rem < RANGE, so the sum never exceeds MAX_VAL.
                    value_nxt_s = MIN_W + rem_step_s[WIDTH-1:0];
                    valid_nxt_s = 1'b1;
                    ready_nxt_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    ready_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                ready_nxt_s = 1'b1;
            end
        endcase
    end

    // LFSR register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= lfsr_nxt_s;
        end
    end

    // FSM state and datapath registers; reset aborts any computation.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r  <= ST_IDLE;
            sample_r <= 16'h0000;
            count_r  <= 4'd0;
            rem_r    <= {(WIDTH+1){1'b0}};
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            value_r  <= MIN_W;
        end else begin
            state_r  <= state_nxt_s;
            sample_r <= sample_nxt_s;
            count_r  <= count_nxt_s;
            rem_r    <= rem_nxt_s;
            ready_r  <= ready_nxt_s;
            valid_r  <= valid_nxt_s;
            value_r  <= value_nxt_s;
        end
    end

    assign Ready       = ready_r;
    assign Valid       = valid_r;
    assign RandomValue = value_r;

endmodule

// File: tb/tb_random_range_gen.sv
// Directed bench for random_range_gen: table of post-reset request offsets with
// hand-computed results, plus sequences for busy, streaming, reset and degenerate range.
module tb_random_range_gen;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Req;
    logic        Ready;
    logic        Valid;
    logic [13:0] RandomValue;
    logic        Req2;
    logic        Ready2;
    logic        Valid2;
    logic [3:0]  RandomValue2;
`ifdef RANDOM_SEED_LOAD_EN
    logic [15:0] Seed;
    logic        SeedLoad;
`endif

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    random_range_gen #(.WIDTH(14), .MIN_VAL(1000), .MAX_VAL(3000), .SEED(16'hACE1)) dut (
        .Clk(Clk), .Rst(Rst),
`ifdef RANDOM_SEED_LOAD_EN
        .Seed(Seed), .SeedLoad(SeedLoad),
`endif
        .Req(Req), .Ready(Ready), .Valid(Valid), .RandomValue(RandomValue)
    );

    random_range_gen #(.WIDTH(4), .MIN_VAL(5), .MAX_VAL(5), .SEED(16'hACE1)) dut_small (
        .Clk(Clk), .Rst(Rst),
`ifdef RANDOM_SEED_LOAD_EN
        .Seed(16'h0000), .SeedLoad(1'b0),
`endif
        .Req(Req2), .Ready(Ready2), .Valid(Valid2), .RandomValue(RandomValue2)
    );

    typedef struct {
        int idle;
        int exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        Rst  = 1'b1;
        Req  = 1'b0;
        Req2 = 1'b0;
        tick();
        Rst  = 1'b0;
    endtask

    // Reference LFSR advanced n times from the reset seed.
    function automatic logic [15:0] lfsr_adv(input int n);
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        return l;
    endfunction

    // One request; checks Ready drop, latency 16 and the returned value.
    task automatic run_req(input string name, input int exp_val);
        int lat;
        int rdy_bad;
        lat = -1;
        rdy_bad = 0;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        check({name, "_ready_low"}, 32'(Ready), 32'd0);
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (Valid) begin
                lat = j;
                break;
            end
            if (Ready) rdy_bad++;
        end
        check({name, "_latency"}, 32'(lat), 32'd16);
        check({name, "_value"}, 32'(RandomValue), 32'(exp_val));
        check({name, "_ready_busy"}, 32'(rdy_bad), 32'd0);
    endtask

    initial begin
        int npulse;
        int at;
        int last;
        int unstable;
        int out_range;
        int pcount;
        int model_bad;
        int lat2;

        // {idle cycles after reset before Req, expected value}
        vecs[0] = '{0, 1235};
        vecs[1] = '{1, 1968};
        vecs[2] = '{2, 2937};
        vecs[3] = '{3, 1370};
        vecs[4] = '{4, 1740};

        Req  = 1'b0;
        Req2 = 1'b0;
        Rst  = 1'b1;
`ifdef RANDOM_SEED_LOAD_EN
        Seed     = 16'h0000;
        SeedLoad = 1'b0;
`endif
        tick();
        tick();

        // Reset state, and Rst winning over Req on the same edge.
        Req = 1'b1;
        tick();
        Req = 1'b0;
        Rst = 1'b0;
        check("reset_ready", 32'(Ready), 32'd1);
        check("reset_valid", 32'(Valid), 32'd0);
        check("reset_value", 32'(RandomValue), 32'd1000);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            repeat (vecs[v].idle) tick();
            run_req($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Req pulsed during BUSY is ignored.
        do_reset();
        Req = 1'b1;
        tick();
        npulse = 0;
        at = -1;
        unstable = 0;
        for (int j = 1; j <= 40; j++) begin
            Req = (j == 5);
            tick();
            if (Valid) begin
                npulse++;
                at = j;
            end
            if (j <= 15 && Ready) unstable++;
        end
        Req = 1'b0;
        check("busy_req_pulses", 32'(npulse), 32'd1);
        check("busy_req_at", 32'(at), 32'd16);
        check("busy_req_ready", 32'(unstable), 32'd0);
        check("busy_req_value", 32'(RandomValue), 32'd1235);

        // Req held for 100 cycles: pulses every 17, in range, stable between.
        do_reset();
        Req = 1'b1;
        pcount = 0;
        last = -1;
        unstable = 0;
        out_range = 0;
        model_bad = 0;
        for (int j = 1; j <= 100; j++) begin
            tick();
            if (Valid) begin
                pcount++;
                check($sformatf("stream_period%0d", pcount), 32'(j), 32'(17 * pcount));
                if (RandomValue < 14'd1000 || RandomValue > 14'd3000) out_range++;
                if (32'(RandomValue) != 32'(1000 + (int'(lfsr_adv(17 * (pcount - 1))) % 2001)))
                    model_bad++;
                last = int'(RandomValue);
            end else if (last >= 0 && int'(RandomValue) != last) begin
                unstable++;
            end
        end
        Req = 1'b0;
        check("stream_pulses", 32'(pcount), 32'd5);
        check("stream_range", 32'(out_range), 32'd0);
        check("stream_stable", 32'(unstable), 32'd0);
        check("stream_model", 32'(model_bad), 32'd0);

        // Reset at edge k+8 aborts the computation.
        do_reset();
        repeat (3) tick();
        run_req("pre_abort", 1370);
        Req = 1'b1;
        tick();
        Req = 1'b0;
        repeat (7) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("abort_valid", 32'(Valid), 32'd0);
        check("abort_value", 32'(RandomValue), 32'd1000);
        check("abort_ready", 32'(Ready), 32'd1);
        npulse = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (Valid) npulse++;
        end
        check("abort_no_valid", 32'(npulse), 32'd0);

        // Degenerate range MIN_VAL=MAX_VAL=5.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            repeat (r * 3) tick();
            Req2 = 1'b1;
            tick();
            Req2 = 1'b0;
            lat2 = -1;
            for (int j = 1; j <= 20; j++) begin
                tick();
                if (Valid2) begin
                    lat2 = j;
                    break;
                end
            end
            check($sformatf("small%0d_latency", r), 32'(lat2), 32'd16);
            check($sformatf("small%0d_value", r), 32'(RandomValue2), 32'd5);
            check($sformatf("small%0d_ready", r), 32'(Ready2), 32'd1);
        end

`ifdef RANDOM_SEED_LOAD_EN
        do_reset();
        Seed = 16'd4003;
        SeedLoad = 1'b1;
        tick();
        SeedLoad = 1'b0;
        run_req("seed4003", 1001);
        Seed = 16'd2000;
        SeedLoad = 1'b1;
        tick();
        SeedLoad = 1'b0;
        run_req("seed2000", 3000);
        Seed = 16'd0;
        SeedLoad = 1'b1;
        tick();
        SeedLoad = 1'b0;
        run_req("seed0", 1235);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/random_range_gen.md
# random_range_gen

Parametrised pseudo-random value generator for the reaction-timer datapath. Replaces the fixed-step counter generator. A free-running 16-bit LFSR is sampled on request and reduced modulo the configured range with a fixed-latency restoring remainder unit. The result is returned as `MIN_VAL + (sample mod RANGE)` with a ready/valid handshake.

## Interface
- `WIDTH`, 14: output width; 1..16.
- `MIN_VAL`, 1000: smallest value produced.
- `MAX_VAL`, 3000: largest value produced; `MIN_VAL <= MAX_VAL < 2**WIDTH`.
- `SEED`, 16'hACE1: LFSR reset and substitute seed; must be nonzero.
- `Clk  in  1`: clock, all logic on rising edge.
- `Rst  in  1`: synchronous, active-high reset.
- `Req  in  1`: request a new value; accepted only when `Ready`=1.
- `Ready  out  1`: high while idle.
- `Valid  out  1`: one-cycle pulse when `RandomValue` is updated.
- `RandomValue  out  WIDTH`: last produced value; holds between results.
- `Seed  in  16`: seed to load; present only with `RANDOM_SEED_LOAD_EN`.
- `SeedLoad  in  1`: load strobe; present only with `RANDOM_SEED_LOAD_EN`.

## Operation
- `RANGE = MAX_VAL - MIN_VAL + 1`, computed at elaboration.
- LFSR:
  - 16-bit Fibonacci register, shift left, `fb = l[15]^l[13]^l[12]^l[10]`, next state `{l[14:0], fb}`.
  - Advances every non-reset cycle, including while busy.
- States:
  - IDLE: `Ready`=1. When `Req` is sampled high: capture `sample` = current LFSR value (pre-edge), clear `rem`, clear the iteration count, go to BUSY.
  - BUSY: `Ready`=0. Each cycle performs one restoring step, MSB of `sample` first: `rem = {rem, bit}`; if `rem >= RANGE`, then `rem -= RANGE`.
  - The 16th step writes `RandomValue <= MIN_VAL + rem_new`, sets `Valid` for one cycle, and returns to IDLE.
- Widths: `rem` is WIDTH+1 bits; the add is WIDTH bits and never overflows, because the result is at most `MAX_VAL`.
- `Req` while BUSY is ignored; it is not queued.
- `Req` held high continuously produces a back-to-back stream: a new capture on the edge after each `Valid` edge.
- Reset (also mid-BUSY aborts with no result):
  - LFSR=`SEED`, state IDLE, `Ready`=1, `Valid`=0, `RandomValue`=`MIN_VAL`.
  - Iteration count and `rem` cleared.

## Timing
- `Req` sampled high at edge k: `Ready` falls after edge k.
- Steps run on edges k+1..k+16; `RandomValue` and `Valid` are registered at edge k+16.
- `Valid` is high for exactly the cycle after edge k+16; `Ready` rises in that same cycle.
- Fixed latency: 16 cycles from accept edge to result edge. Minimum request period is 17 cycles.
- `Rst` has priority over all other inputs on the same edge.

## Configuration
- `RANDOM_SEED_LOAD_EN` defined:
  - `Seed` and `SeedLoad` ports exist.
  - `SeedLoad` high at an edge sets the LFSR to `Seed`, or to `SEED` if `Seed`=0. This replaces that edge's shift.
  - Allowed in any state. A BUSY computation continues on its captured sample.
  - `Req` on the same edge captures the pre-load LFSR value.
- Undefined: the ports are absent, the LFSR is seeded only by reset, and behaviour is otherwise identical.

## Test plan
- Reset, then `Req` sampled on the first post-reset edge (LFSR=16'hACE1 = 44257) -> `Valid` 16 edges later, `RandomValue`=1235; the LFSR value on the following edge is 16'h59C3.
- `RANDOM_SEED_LOAD_EN`: `SeedLoad` with `Seed`=4003, `Req` on the next edge -> `RandomValue`=1001; with `Seed`=2000 -> 3000; with `Seed`=0 -> 1235.
- `Req` pulsed again during BUSY -> ignored; exactly one `Valid` pulse, `Ready`=0 throughout edges k+1..k+16.
- `Req` held high for 100 cycles -> `Valid` pulses every 17 cycles; every value is within 1000..3000; `RandomValue` is stable between pulses.
- `Rst` asserted at edge k+8 of a BUSY computation -> no `Valid`, `RandomValue`=1000, `Ready`=1 on the next cycle.
- `MIN_VAL`=`MAX_VAL`=5, `WIDTH`=4 -> every result equals 5, latency still 16 cycles.
